// File: rtl/window_gen.sv
// window_gen: buffers one IMG_W x IMG_H raster frame, then emits every KxK window (X outer, Y inner) for simpleCNN.
// Latency: first window valid the cycle after pixel 783 is accepted; one cycle later with `WINGEN_CNN_START_EN (ARM state drives CNN_START).
// Backpressure: PIX_READY only in LOAD; IMGIN/X/Y hold and coordinates freeze while WIN_VALID & !WIN_READY.
module window_gen #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 5,
   parameter int PIX_W = 8
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 START,
   input  logic                 PIX_VALID,
   input  logic [PIX_W-1:0]     PIX_IN,
   output logic                 PIX_READY,
   output logic                 WIN_VALID,
   input  logic                 WIN_READY,
   output logic [K*K*PIX_W-1:0] IMGIN,
   output logic [4:0]           X,
   output logic [4:0]           Y,
`ifdef WINGEN_CNN_START_EN
   output logic                 CNN_START,
`endif
   output logic                 FRAME_DONE
);

   localparam int         NPIX = IMG_W * IMG_H;
   localparam int         AW   = $clog2(NPIX);
   localparam logic [4:0] XMAX = 5'(IMG_W - K);
   localparam logic [4:0] YMAX = 5'(IMG_H - K);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_EMIT = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
`ifdef WINGEN_CNN_START_EN
   localparam logic [2:0] S_ARM  = 3'd4;
`endif

   logic [2:0]           state;
   logic [AW-1:0]        wr_addr;
   logic [PIX_W-1:0]     fbuf [NPIX];
   logic [4:0]           nx;
   logic [4:0]           ny;
   logic [K*K*PIX_W-1:0] win_nxt;
   logic                 pix_acc;
   logic                 win_acc;
   logic                 last_win;
   logic                 last_pix;

   assign pix_acc  = PIX_VALID & PIX_READY;
   assign win_acc  = WIN_VALID & WIN_READY;
   assign last_win = (X == XMAX) && (Y == YMAX);
   assign last_pix = (wr_addr == AW'(NPIX - 1));

   // Frame buffer write in raster order; contents deliberately survive reset.
   always_ff @(posedge CLK) begin
      if (pix_acc) fbuf[wr_addr] <= PIX_IN;
   end

   // Coordinates of the window to load at this edge: origin when entering EMIT, else next in X-outer/Y-inner order.
   always_comb begin
      nx = '0;
      ny = '0;
      if (state == S_EMIT) begin
         if (Y == YMAX) begin
            nx = X + 5'd1;
            ny = '0;
         end else begin
            nx = X;
            ny = Y + 5'd1;
         end
      end
   end

   // Gather the KxK window at (nx, ny); row offset i, col offset j, p(ny,nx) lands in the top byte.
   always_comb begin
      win_nxt = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            win_nxt[(K*K-1-(K*i+j))*PIX_W +: PIX_W] =
               fbuf[AW'((int'(ny) + i) * IMG_W + int'(nx) + j)];
         end
      end
   end

   // Control FSM plus registered window outputs and coordinate counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= S_IDLE;
         wr_addr    <= '0;
         PIX_READY  <= 1'b0;
         WIN_VALID  <= 1'b0;
         IMGIN      <= '0;
         X          <= '0;
         Y          <= '0;
         FRAME_DONE <= 1'b0;
`ifdef WINGEN_CNN_START_EN
         CNN_START  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  state     <= S_LOAD;
                  wr_addr   <= '0;
                  PIX_READY <= 1'b1;
               end
            end
            S_LOAD: begin
               if (pix_acc) begin
                  if (last_pix) begin
                     PIX_READY <= 1'b0;
                     wr_addr   <= '0;
`ifdef WINGEN_CNN_START_EN
                     state     <= S_ARM;
                     CNN_START <= 1'b1;
`else
                     // Window (0,0) never touches the final pixel, so it can be loaded at this same edge.
                     state     <= S_EMIT;
                     WIN_VALID <= 1'b1;
                     IMGIN     <= win_nxt;
                     X         <= '0;
                     Y         <= '0;
`endif
                  end else begin
                     wr_addr <= wr_addr + AW'(1);
                  end
               end
            end
`ifdef WINGEN_CNN_START_EN
            S_ARM: begin
               CNN_START <= 1'b0;
               state     <= S_EMIT;
               WIN_VALID <= 1'b1;
               IMGIN     <= win_nxt;
               X         <= '0;
               Y         <= '0;
            end
`endif
            S_EMIT: begin
               if (win_acc) begin
                  if (last_win) begin
                     WIN_VALID  <= 1'b0;
                     FRAME_DONE <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     IMGIN <= win_nxt;
                     X     <= nx;
                     Y     <= ny;
                  end
               end
            end
            S_DONE: begin
               FRAME_DONE <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed bench for window_gen with a pixel-pattern model p(r,c) = (28r+c) mod 256.
// Latency: checks first window one cycle after the last pixel (two with WINGEN_CNN_START_EN).
// Backpressure: exercises random PIX_VALID gaps and random WIN_READY stalls, checking output hold.
module tb_window_gen;

   logic         CLK = 1'b0;
   logic         nRST = 1'b1;
   logic         START = 1'b0;
   logic         PIX_VALID = 1'b0;
   logic [7:0]   PIX_IN = 8'd0;
   logic         PIX_READY;
   logic         WIN_VALID;
   logic         WIN_READY = 1'b0;
   logic [199:0] IMGIN;
   logic [4:0]   X;
   logic [4:0]   Y;
   logic         FRAME_DONE;
`ifdef WINGEN_CNN_START_EN
   logic         CNN_START;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   window_gen dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .START      (START),
      .PIX_VALID  (PIX_VALID),
      .PIX_IN     (PIX_IN),
      .PIX_READY  (PIX_READY),
      .WIN_VALID  (WIN_VALID),
      .WIN_READY  (WIN_READY),
      .IMGIN      (IMGIN),
      .X          (X),
      .Y          (Y),
`ifdef WINGEN_CNN_START_EN
      .CNN_START  (CNN_START),
`endif
      .FRAME_DONE (FRAME_DONE)
   );

   task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expected window from the image pattern: byte (5i+j) from the top is p(y+i, x+j).
   function automatic logic [199:0] model_win(input int x, input int y);
      logic [199:0] w;
      w = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            w[199-8*(5*i+j) -: 8] = 8'((28*(y+i) + x + j) % 256);
      return w;
   endfunction

   task automatic load_frame(input bit gaps, input int start_at);
      int n   = 0;
      int cyc = 0;
      bit acc;
      START = 1'b1;
      tick();
      START = 1'b0;
      check("pix_ready_rise", PIX_READY, 1);
      while (n < 784 && cyc < 5000) begin
         PIX_VALID = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         PIX_IN    = 8'(n);
         START     = (n == start_at);
         acc       = PIX_VALID && PIX_READY;
         tick();
         cyc++;
         if (acc) n++;
      end
      PIX_VALID = 1'b0;
      START     = 1'b0;
      check("pix_count", n, 784);
      check("pix_ready_fall", PIX_READY, 0);
`ifdef WINGEN_CNN_START_EN
      check("arm_cnn_start", CNN_START, 1);
      check("arm_win_valid", WIN_VALID, 0);
      tick();
      check("cnn_start_pulse", CNN_START, 0);
`endif
      check("first_valid", WIN_VALID, 1);
      check("first_xy", {X, Y}, 0);
   endtask

   task automatic emit_frame(input bit rnd, input int start_at, input int rst_at);
      int           nacc = 0;
      int           vcyc = 0;
      int           cyc  = 0;
      int           ex   = 0;
      int           ey   = 0;
      logic [199:0] prev_img = '0;
      logic [9:0]   prev_xy  = '0;
      bit           stalled  = 1'b0;
      while (nacc < 576 && cyc < 20000) begin
         if (nacc == rst_at) begin
            nRST = 1'b0;
            #1;
            check("rst_win_valid", WIN_VALID, 0);
            check("rst_imgin", IMGIN, 0);
            check("rst_xy", {X, Y}, 0);
            check("rst_pix_ready", PIX_READY, 0);
            check("rst_frame_done", FRAME_DONE, 0);
            WIN_READY = 1'b0;
            START     = 1'b0;
            tick();
            nRST = 1'b1;
            tick();
            check("rst_idle_pix_ready", PIX_READY, 0);
            return;
         end
         WIN_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         START     = (nacc == start_at);
         if (WIN_VALID) begin
            vcyc++;
            if (stalled) begin
               check("hold_imgin", IMGIN, prev_img);
               check("hold_xy", {X, Y}, prev_xy);
            end
            if (WIN_READY) begin
               check("win_xy", {X, Y}, {5'(ex), 5'(ey)});
               check("win_dat", IMGIN, model_win(ex, ey));
               check("no_early_done", FRAME_DONE, 0);
               if (nacc == 0) begin
                  check("w00_b0", IMGIN[199:192], 8'h00);
                  check("w00_b1", IMGIN[191:184], 8'h01);
                  check("w00_b5", IMGIN[159:152], 8'h1C);
                  check("w00_b24", IMGIN[7:0], 8'h74);
               end
               if (nacc == 24)  check("order_after_0_23", {X, Y}, {5'd1, 5'd0});
               if (nacc == 552) check("order_after_22_23", {X, Y}, {5'd23, 5'd0});
               if (nacc == 575) begin
                  check("w2323_b0", IMGIN[199:192], 8'h9B);
                  check("w2323_b24", IMGIN[7:0], 8'h0F);
               end
               nacc++;
               if (ey == 23) begin
                  ey = 0;
                  ex++;
               end else begin
                  ey++;
               end
            end
         end
         stalled  = WIN_VALID && !WIN_READY;
         prev_img = IMGIN;
         prev_xy  = {X, Y};
         tick();
         cyc++;
      end
      START = 1'b0;
      check("win_count", nacc, 576);
      if (!rnd) check("valid_cycles", vcyc, 576);
      check("done_valid_low", WIN_VALID, 0);
      check("frame_done", FRAME_DONE, 1);
      WIN_READY = 1'b0;
      START     = 1'b1;
      tick();
      START = 1'b0;
      check("frame_done_pulse", FRAME_DONE, 0);
      check("start_in_done_ignored", PIX_READY, 0);
      tick();
      check("idle_pix_ready", PIX_READY, 0);
   endtask

   initial begin
      #2;
      nRST = 1'b0;
      tick();
      tick();
      check("reset_pix_ready", PIX_READY, 0);
      check("reset_win_valid", WIN_VALID, 0);
      check("reset_imgin", IMGIN, 0);
      check("reset_xy", {X, Y}, 0);
      check("reset_frame_done", FRAME_DONE, 0);
`ifdef WINGEN_CNN_START_EN
      check("reset_cnn_start", CNN_START, 0);
`endif
      nRST = 1'b1;
      tick();

      // Clean frame with stray START pulses in LOAD and EMIT.
      load_frame(1'b0, 100);
      emit_frame(1'b0, 50, -1);

      // Pixel gaps and random window backpressure.
      load_frame(1'b1, -1);
      emit_frame(1'b1, -1, -1);

      // Reset mid-emission, then a fresh frame.
      load_frame(1'b0, -1);
      emit_frame(1'b0, -1, 300);
      load_frame(1'b0, -1);
      emit_frame(1'b0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/window_gen.md
# window_gen

Upstream feeder for `simpleCNN`. Accepts one 28×28 8-bit image as a raster-order pixel stream, stores it in an internal frame buffer, then emits all 24×24 5×5 windows on the 200-bit `IMGIN` bus. Emission order and bit packing match what `simpleCNN` consumes, with `X`/`Y` window coordinates alongside. Sits between the image source (memory/DMA) and `simpleCNN`.

## Interface
- `IMG_W`, 28, image width in pixels
- `IMG_H`, 28, image height in pixels
- `K`, 5, window edge
- `PIX_W`, 8, bits per pixel
- `CLK`  in  1  clock, rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `START`  in  1  begin a frame; sampled only in IDLE
- `PIX_VALID`  in  1  `PIX_IN` valid
- `PIX_IN`  in  8  pixel, raster order (row 0 col 0 first)
- `PIX_READY`  out  1  high in LOAD; pixel accepted on `PIX_VALID & PIX_READY`
- `WIN_VALID`  out  1  `IMGIN`/`X`/`Y` hold a valid window
- `WIN_READY`  in  1  consumer accepts window on `WIN_VALID & WIN_READY`
- `IMGIN`  out  200  K·K·PIX_W window
- `X`  out  5  window column, 0..23
- `Y`  out  5  window row, 0..23
- `FRAME_DONE`  out  1  one-cycle pulse after the last window is accepted

## Operation
- Frame buffer: IMG_W·IMG_H × PIX_W registers. Write address counter 0..783.
- FSM states IDLE, LOAD, EMIT, DONE:
  - IDLE → LOAD on `START`.
  - LOAD → EMIT when pixel 783 is accepted.
  - EMIT → DONE when window (X=23, Y=23) is accepted.
  - DONE → IDLE unconditionally after one cycle.
- `START` is ignored outside IDLE. `PIX_VALID` is ignored outside LOAD.
- Window order: X outer, Y inner: (0,0),(0,1)…(0,23),(1,0)…(23,23). 576 windows total.
- Packing, with p(r,c) the pixel at row r, col c:
  - `IMGIN[199-8·(5·i+j) -: 8]` = p(Y+i, X+j), for i = row offset 0..4 and j = col offset 0..4.
  - So `IMGIN[199:192]` = p(Y,X) and `IMGIN[7:0]` = p(Y+4,X+4).
- `IMGIN`, `X`, `Y` are registered. They stay stable while `WIN_VALID & !WIN_READY`.
- Reset values: `PIX_READY`=0, `WIN_VALID`=0, `IMGIN`=0, `X`=0, `Y`=0, `FRAME_DONE`=0, FSM=IDLE, counters=0.
- Frame buffer contents are not reset.

## Timing
- `PIX_READY` rises the cycle after `START` is sampled in IDLE. Accepting one pixel per cycle gives a 784-cycle LOAD.
- First window: `WIN_VALID` is high with X=0, Y=0 in the cycle after the edge that accepts pixel 783.
- Throughput: one window per cycle while `WIN_READY`=1. On each accept edge the next window is loaded at that same edge, with no bubble.
- `WIN_READY` low: all window outputs hold and the coordinate counters freeze.
- Last accept (X=23, Y=23) → next cycle: `WIN_VALID`=0, `FRAME_DONE`=1 for exactly one cycle (DONE state), then IDLE.
- `START` asserted in the DONE cycle is ignored. `START` asserted in the following IDLE cycle starts a new frame.
- `nRST` low at any time, including mid-LOAD or mid-EMIT, immediately forces reset values. A partially loaded frame is abandoned, and a new `START` is required.

## Configuration
- `WINGEN_CNN_START_EN` defined:
  - Adds output `CNN_START` (1 bit, reset 0).
  - On leaving LOAD, the FSM passes through an extra one-cycle state ARM in which `CNN_START`=1 and `WIN_VALID`=0.
  - EMIT starts the next cycle, so the first window arrives one cycle later than stated in Timing.
  - This drives `simpleCNN`'s `START` directly.
- Not defined: no `CNN_START` port and no ARM state. Timing is exactly as stated above.

## Test plan
- Full frame, p(r,c) = (28r+c) mod 256, `WIN_READY`=1:
  - Window (0,0): `IMGIN[199:192]`=0x00, `[191:184]`=0x01, `[159:152]`=0x1C, `[7:0]`=0x74.
  - Window (23,23): `[199:192]`=0x9B, `[7:0]`=0x0F.
  - Exactly 576 `WIN_VALID` cycles, then a single `FRAME_DONE` pulse.
- Order check: the accept after (X=0, Y=23) shows X=1, Y=0. The accept after (X=22, Y=23) shows X=23, Y=0.
- Backpressure:
  - Random `WIN_READY` (50%) and random `PIX_VALID` gaps.
  - `IMGIN`/`X`/`Y` hold stable while stalled.
  - Accepted window sequence is identical to the no-stall run.
- `START` pulsed during LOAD at pixel 100 and during EMIT at window 50: no effect; pixel count and window count are unchanged.
- `nRST` pulsed at window 300:
  - All outputs return to 0 and `PIX_READY`=0.
  - A new `START` plus a full frame yields a correct (0,0) window.
- With `WINGEN_CNN_START_EN`: `CNN_START`=1 for one cycle with `WIN_VALID`=0, then (0,0) is valid the next cycle.
